spi_register_controller: RTL and testbench

Serial front end for the synth's configuration register file. Receives register writes over a mode-0 SPI link (SCK/CS_n/MOSI, asynchronous to `i_Clock`) and synchronizes them into the `i_Clock` domain. Decodes each frame into a 16-bit register number and one or more 8-bit values. Issues single-cycle writes that drive the synth's `i_RegisterWriteEnable`/`i_RegisterWriteNumber`/`i_RegisterWriteValue` inputs directly.

---
 rtl/spi_register_controller_pkg.sv | 6 +
 rtl/spi_register_controller_sync_ff.sv | 16 +
 rtl/spi_register_controller.sv | 127 ++++++++++++
 tb/tb_spi_register_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/spi_register_controller_pkg.sv
// spi_register_controller_pkg: frame field widths and controller state encoding
package spi_register_controller_pkg;
  localparam int SPI_HEADER_BITS = 16;
  localparam int SPI_DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, HEADER, DATA} SpiCtrlState_t;
endpackage

// File: rtl/spi_register_controller_sync_ff.sv
// sync_ff: SYNC_STAGES-deep single-bit synchronizer with selectable reset value
module sync_ff #(
  parameter int SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sr;
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) sr <= {SYNC_STAGES{RESET_VALUE}};
    else sr <= {sr[SYNC_STAGES-2:0], d};
  assign q = sr[SYNC_STAGES-1];
endmodule

// File: rtl/spi_register_controller.sv
// spi_register_controller: mode-0 SPI frames decoded into single-cycle register writes
module spi_register_controller
  import spi_register_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit ADDR_AUTO_INCREMENT = 1'b1
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_SpiSck,
  input  logic        i_SpiCs_n,
  input  logic        i_SpiMosi,
  output logic        o_RegisterWriteEnable,
  output logic [15:0] o_RegisterWriteNumber,
  output logic [7:0]  o_RegisterWriteValue,
  output logic        o_FrameError,
  output logic        o_Busy
);
  logic sck_s, cs_s, mosi_s, sck_prev, cs_prev, armed, flushed;
  logic sck_rise, cs_fall, cs_rise;
  logic [7:0] fill;
  SpiCtrlState_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [SPI_HEADER_BITS-2:0] hdr_sr, hdr_n;
  logic [SPI_DATA_BITS-2:0] dat_sr, dat_n;
  logic [15:0] num, num_n, wnum_n;
  logic [7:0] wval_n;
  logic we_n, err_n, busy_n;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sck (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .d(i_SpiSck), .q(sck_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_cs (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .d(i_SpiCs_n), .q(cs_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_mosi (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .d(i_SpiMosi), .q(mosi_s));

  // Synchronizer outputs carry reset values until the pins have propagated;
  // CS must then be seen high before a falling edge can open a frame.
  assign flushed = fill == 8'(SYNC_STAGES);
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
      armed    <= 1'b0;
      fill     <= '0;
    end else begin
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
      armed    <= armed | (flushed & cs_s);
      fill     <= flushed ? fill : fill + 8'd1;
    end

  assign sck_rise = sck_s & ~sck_prev;
  assign cs_fall  = armed & cs_prev & ~cs_s;
  assign cs_rise  = armed & ~cs_prev & cs_s;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hdr_n   = hdr_sr;
    dat_n   = dat_sr;
    num_n   = num;
    wnum_n  = o_RegisterWriteNumber;
    wval_n  = o_RegisterWriteValue;
    we_n    = 1'b0;
    err_n   = 1'b0;
    busy_n  = o_Busy;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (cs_fall) begin
          state_n = HEADER;
          busy_n  = 1'b1;
        end
      end
      HEADER, DATA: begin
        // A CS rise in the same cycle as an SCK rise discards that bit
        if (cs_rise) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          err_n   = cnt != 4'd0;
          cnt_n   = '0;
        end else if (sck_rise && state == HEADER) begin
          hdr_n   = {hdr_sr[SPI_HEADER_BITS-3:0], mosi_s};
          cnt_n   = cnt == 4'(SPI_HEADER_BITS-1) ? 4'd0 : cnt + 4'd1;
          num_n   = cnt == 4'(SPI_HEADER_BITS-1) ? {hdr_sr, mosi_s} : num;
          state_n = cnt == 4'(SPI_HEADER_BITS-1) ? DATA : HEADER;
        end else if (sck_rise) begin
          dat_n = {dat_sr[SPI_DATA_BITS-3:0], mosi_s};
          cnt_n = cnt == 4'(SPI_DATA_BITS-1) ? 4'd0 : cnt + 4'd1;
          if (cnt == 4'(SPI_DATA_BITS-1)) begin
            we_n   = 1'b1;
            wnum_n = num;
            wval_n = {dat_sr, mosi_s};
            num_n  = num + 16'(ADDR_AUTO_INCREMENT);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      state                 <= IDLE;
      cnt                   <= '0;
      hdr_sr                <= '0;
      dat_sr                <= '0;
      num                   <= '0;
      o_RegisterWriteEnable <= 1'b0;
      o_RegisterWriteNumber <= '0;
      o_RegisterWriteValue  <= '0;
      o_FrameError          <= 1'b0;
      o_Busy                <= 1'b0;
    end else begin
      state                 <= state_n;
      cnt                   <= cnt_n;
      hdr_sr                <= hdr_n;
      dat_sr                <= dat_n;
      num                   <= num_n;
      o_RegisterWriteEnable <= we_n;
      o_RegisterWriteNumber <= wnum_n;
      o_RegisterWriteValue  <= wval_n;
      o_FrameError          <= err_n;
      o_Busy                <= busy_n;
    end
endmodule

// File: tb/tb_spi_register_controller.sv
// tb_spi_register_controller: table-driven and random SPI frames against a frame-level model
module tb_spi_register_controller;
  logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic we_a, we_b, err_a, err_b, busy_a, busy_b;
  logic [15:0] num_a, num_b;
  logic [7:0] val_a, val_b;
  int checks = 0, errors = 0;
  int stb_a = 0, stb_b = 0, errc_a = 0, errc_b = 0, cyc = 0, last_a = -1000;

  always #5 clk = ~clk;

  spi_register_controller #(.SYNC_STAGES(2), .ADDR_AUTO_INCREMENT(1'b1)) dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_SpiSck(sck), .i_SpiCs_n(cs_n), .i_SpiMosi(mosi),
    .o_RegisterWriteEnable(we_a), .o_RegisterWriteNumber(num_a), .o_RegisterWriteValue(val_a),
    .o_FrameError(err_a), .o_Busy(busy_a));
  spi_register_controller #(.SYNC_STAGES(2), .ADDR_AUTO_INCREMENT(1'b0)) dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_SpiSck(sck), .i_SpiCs_n(cs_n), .i_SpiMosi(mosi),
    .o_RegisterWriteEnable(we_b), .o_RegisterWriteNumber(num_b), .o_RegisterWriteValue(val_b),
    .o_FrameError(err_b), .o_Busy(busy_b));

  typedef struct { logic [15:0] num; logic [7:0] val; } wr_t;
  typedef struct {
    logic [15:0] hdr; logic [31:0] data; int nbits; bit collide; int exp_w; bit exp_err;
  } vec_t;
  wr_t qa[$], qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_bit(input logic b);
    mosi = b;
    wait_clk(4);
    sck = 1'b1;
    wait_clk(4);
    sck = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rst_n) begin
    if (we_a) begin
      stb_a++;
      check("strobe_expected_a", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) begin
        check("number_a", 32'(num_a), 32'(qa[0].num));
        check("value_a", 32'(val_a), 32'(qa[0].val));
        void'(qa.pop_front());
      end
      check("strobe_gap_a", 32'(cyc - last_a >= 64), 32'd1);
      last_a = cyc;
    end
    if (we_b) begin
      stb_b++;
      check("strobe_expected_b", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) begin
        check("number_b", 32'(num_b), 32'(qb[0].num));
        check("value_b", 32'(val_b), 32'(qb[0].val));
        void'(qb.pop_front());
      end
    end
    if (err_a) errc_a++;
    if (err_b) errc_b++;
  end

  // Model: every complete byte after a 16-bit header is one write; a frame
  // that stops short of a field boundary is an error.
  task automatic run_frame(input logic [15:0] hdr, input logic [31:0] data, input int nbits,
                           input bit collide, input int exp_w, input bit exp_err);
    logic [47:0] bits;
    logic [15:0] na;
    int eff;
    bits = {hdr, data};
    eff = collide ? nbits - 1 : nbits;
    na = hdr;
    for (int k = 0; 16 + 8 * (k + 1) <= eff; k++) begin
      qa.push_back('{na, data[31-8*k -: 8]});
      qb.push_back('{hdr, data[31-8*k -: 8]});
      na = na + 16'd1;
    end
    stb_a = 0; stb_b = 0; errc_a = 0; errc_b = 0;
    cs_n = 1'b0;
    wait_clk(6);
    check("busy_in_frame", 32'(busy_a & busy_b), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (collide && i == nbits - 1) begin
        mosi = bits[47-i];
        wait_clk(4);
        sck = 1'b1;
        cs_n = 1'b1;
        wait_clk(4);
        sck = 1'b0;
      end else sck_bit(bits[47-i]);
    end
    if (!collide) begin
      wait_clk(4);
      cs_n = 1'b1;
    end
    wait_clk(8);
    check("busy_after_frame", 32'(busy_a | busy_b), 32'd0);
    check("strobes_a", 32'(stb_a), 32'(exp_w));
    check("strobes_b", 32'(stb_b), 32'(exp_w));
    check("frame_error_a", 32'(errc_a), 32'(exp_err));
    check("frame_error_b", 32'(errc_b), 32'(exp_err));
    check("pending_writes", 32'(qa.size() + qb.size()), 32'd0);
    qa.delete();
    qb.delete();
  endtask

  vec_t vt[9];

  initial begin
    vt = '{
      '{16'hC001, 32'hA5000000, 24, 1'b0, 1, 1'b0},
      '{16'hC0FF, 32'h11223300, 40, 1'b0, 3, 1'b0},
      '{16'hFFFF, 32'h01020000, 32, 1'b0, 2, 1'b0},
      '{16'h8000, 32'hF8000000, 21, 1'b0, 0, 1'b1},
      '{16'h8000, 32'h7E000000, 24, 1'b0, 1, 1'b0},
      '{16'h1234, 32'h00000000, 16, 1'b0, 0, 1'b0},
      '{16'hABCD, 32'h00000000, 9,  1'b0, 0, 1'b1},
      '{16'h4242, 32'h5A000000, 24, 1'b1, 0, 1'b1},
      '{16'h0000, 32'h00000000, 0,  1'b0, 0, 1'b0}
    };
    wait_clk(3);
    check("reset_outputs", {14'd0, we_a, err_a, busy_a, num_a | num_b, val_a}, 32'd0);
    rst_n = 1'b1;
    wait_clk(6);
    check("idle_busy", 32'(busy_a), 32'd0);

    foreach (vt[i])
      run_frame(vt[i].hdr, vt[i].data, vt[i].nbits, vt[i].collide, vt[i].exp_w, vt[i].exp_err);

    // Reset in the middle of a header, with CS held low across release
    stb_a = 0; stb_b = 0; errc_a = 0; errc_b = 0;
    cs_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 10; i++) sck_bit(1'(i));
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", {6'd0, we_a, err_a, busy_a, num_a, val_a}, 32'd0);
    wait_clk(3);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      sck_bit(1'(i >> 1));
      if (i == 7) check("busy_after_reset", 32'(busy_a | busy_b), 32'd0);
    end
    wait_clk(4);
    check("busy_cs_still_low", 32'(busy_a | busy_b), 32'd0);
    check("reset_no_strobe", 32'(stb_a + stb_b), 32'd0);
    check("reset_no_error", 32'(errc_a + errc_b), 32'd0);
    cs_n = 1'b1;
    wait_clk(8);
    check("busy_cs_high", 32'(busy_a), 32'd0);
    run_frame(16'h5555, 32'h3C000000, 24, 1'b0, 1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      logic [15:0] h;
      logic [31:0] d;
      int n, e, w;
      bit c, eerr;
      h = 16'($urandom);
      d = $urandom;
      n = ($urandom_range(0, 3) != 0) ? 16 + 8 * $urandom_range(0, 4) : $urandom_range(1, 47);
      c = ($urandom_range(0, 4) == 0);
      e = c ? n - 1 : n;
      w = e >= 16 ? (e - 16) / 8 : 0;
      eerr = (e != 0) && (e < 16 || (e - 16) % 8 != 0);
      run_frame(h, d, n, c, w, eerr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
